mem_access_unit: RTL and testbench

Memory-stage access unit for the vector datapath: consumes the EX/MEM pipeline register outputs and performs the data-memory transaction they describe. It splits a DATA_W-bit vector load or store into sequential BEAT_W-bit single-port RAM accesses and reassembles load data. It stalls the upstream pipeline while busy, then presents a registered result to the MEM/WB boundary. Non-memory instructions pass through with one-register latency.

---
 rtl/mem_access_unit_if.sv | 22 ++
 rtl/mem_access_unit.sv | 174 +++++++++++++++++
 tb/tb_mem_access_unit.sv | 401 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_access_unit_if.sv
// Single-port data RAM bus between the memory access unit (master) and the RAM (slave).
// Read data is returned in the cycle after the read strobe.
interface mem_access_unit_if #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned BEAT_W = 32
);
  logic [ADDR_W-1:0] mem_addr;
  logic [BEAT_W-1:0] mem_wdata;
  logic              mem_we;
  logic              mem_re;
  logic [BEAT_W-1:0] mem_rdata;

  modport master (
    output mem_addr, mem_wdata, mem_we, mem_re,
    input  mem_rdata
  );

  modport slave (
    input  mem_addr, mem_wdata, mem_we, mem_re,
    output mem_rdata
  );
endinterface

// File: rtl/mem_access_unit.sv
// MEM-stage access unit: splits vector loads/stores into sequential RAM beats,
// reassembles load data, stalls upstream while busy and retires one result per instruction.
module mem_access_unit #(
  parameter int unsigned DATA_W = 192,
  parameter int unsigned BEAT_W = 32,
  parameter int unsigned ADDR_W = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                MemToReg_in,
  input  logic                MemRead_in,
  input  logic                MemWrite_in,
  input  logic                VectorOp_in,
  input  logic [DATA_W-1:0]   alu_in,
  input  logic [DATA_W-1:0]   mux1_in,
  input  logic [3:0]          RR_in,
  output logic                stall,
  mem_access_unit_if.master   mem,
  output logic [DATA_W-1:0]   wb_data,
  output logic [3:0]          wb_RR,
  output logic                wb_MemToReg,
  output logic                wb_valid
);

  localparam int unsigned BEATS = DATA_W / BEAT_W;
  localparam int unsigned CNT_W = $clog2(BEATS + 1);
  localparam int unsigned RR_W  = 4;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_DRAIN  = 2'd2
  } state_e;

  state_e              r_state;
  state_e              w_state_nxt;
  logic [CNT_W-1:0]    r_cnt;
  logic [CNT_W-1:0]    r_last;
  logic [ADDR_W-1:0]   r_base;
  logic [DATA_W-1:0]   r_wdata;
  logic [DATA_W-1:0]   r_asm;
  logic [RR_W-1:0]     r_rr;
  logic                r_m2r;
  logic                r_is_wr;

  logic [DATA_W-1:0]   r_wb_data;
  logic [RR_W-1:0]     r_wb_rr;
  logic                r_wb_m2r;
  logic                r_wb_valid;

  logic                w_mem_op;
  logic                w_last;
  logic [DATA_W-1:0]   w_asm;
  logic                w_stall;
  logic [ADDR_W-1:0]   w_addr;
  logic [BEAT_W-1:0]   w_wdata;
  logic                w_we;
  logic                w_re;

  assign w_mem_op = MemRead_in | MemWrite_in;
  assign w_last   = (r_cnt == r_last);

  // State register
  always_ff @(negedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE:   if (w_mem_op) w_state_nxt = S_ACCESS;
      S_ACCESS: if (w_last)   w_state_nxt = r_is_wr ? S_IDLE : S_DRAIN;
      S_DRAIN:  w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  // RAM strobes and stall decoded from state, beat counter and captured operands
  always_comb begin
    w_stall = 1'b0;
    w_addr  = '0;
    w_wdata = '0;
    w_we    = 1'b0;
    w_re    = 1'b0;
    unique case (r_state)
      S_ACCESS: begin
        w_stall = 1'b1;
        w_addr  = r_base + ADDR_W'(r_cnt);
        w_we    = r_is_wr;
        w_re    = ~r_is_wr;
        if (r_is_wr) w_wdata = r_wdata[int'(r_cnt) * BEAT_W +: BEAT_W];
      end
      S_DRAIN: w_stall = 1'b1;
      default: ;
    endcase
  end

  // Read data always belongs to the beat issued one cycle earlier
  always_comb begin
    w_asm = r_asm;
    if (r_cnt != '0) w_asm[(int'(r_cnt) - 1) * BEAT_W +: BEAT_W] = mem.mem_rdata;
  end

  always_ff @(negedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt      <= '0;
      r_last     <= '0;
      r_base     <= '0;
      r_wdata    <= '0;
      r_asm      <= '0;
      r_rr       <= '0;
      r_m2r      <= 1'b0;
      r_is_wr    <= 1'b0;
      r_wb_data  <= '0;
      r_wb_rr    <= '0;
      r_wb_m2r   <= 1'b0;
      r_wb_valid <= 1'b0;
    end else begin
      r_wb_valid <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (w_mem_op) begin
            r_base  <= alu_in[ADDR_W-1:0];
            r_wdata <= mux1_in;
            r_rr    <= RR_in;
            r_m2r   <= MemToReg_in;
            r_is_wr <= MemWrite_in;
            r_last  <= VectorOp_in ? CNT_W'(BEATS - 1) : '0;
            r_cnt   <= '0;
            r_asm   <= '0;
          end else begin
            r_wb_data  <= alu_in;
            r_wb_rr    <= RR_in;
            r_wb_m2r   <= MemToReg_in;
            r_wb_valid <= 1'b1;
          end
        end
        S_ACCESS: begin
          r_cnt <= r_cnt + CNT_W'(1);
          if (!r_is_wr) r_asm <= w_asm;
          if (w_last && r_is_wr) begin
            r_cnt      <= '0;
            r_wb_data  <= '0;
            r_wb_rr    <= r_rr;
            r_wb_m2r   <= r_m2r;
            r_wb_valid <= 1'b1;
          end
        end
        S_DRAIN: begin
          r_cnt      <= '0;
          r_asm      <= w_asm;
          r_wb_data  <= w_asm;
          r_wb_rr    <= r_rr;
          r_wb_m2r   <= r_m2r;
          r_wb_valid <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign stall         = w_stall;
  assign mem.mem_addr  = w_addr;
  assign mem.mem_wdata = w_wdata;
  assign mem.mem_we    = w_we;
  assign mem.mem_re    = w_re;
  assign wb_data       = r_wb_data;
  assign wb_RR         = r_wb_rr;
  assign wb_MemToReg   = r_wb_m2r;
  assign wb_valid      = r_wb_valid;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: directed scenarios plus randomized instruction stream,
// checked against a transaction-level model of beats, stall length and retired results.
module tb_mem_access_unit;

  localparam int unsigned DATA_W = 192;
  localparam int unsigned BEAT_W = 32;
  localparam int unsigned ADDR_W = 16;
  localparam int unsigned BEATS  = 6;

  logic clk = 1'b1;
  logic rst = 1'b1;
  logic MemToReg_in = 1'b0, MemRead_in = 1'b0, MemWrite_in = 1'b0, VectorOp_in = 1'b0;
  logic [DATA_W-1:0] alu_in = '0, mux1_in = '0;
  logic [3:0] RR_in = '0;
  logic stall;
  logic [DATA_W-1:0] wb_data;
  logic [3:0] wb_RR;
  logic wb_MemToReg, wb_valid;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_access_unit_if #(.ADDR_W(ADDR_W), .BEAT_W(BEAT_W)) mif ();

  mem_access_unit #(.DATA_W(DATA_W), .BEAT_W(BEAT_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst),
    .MemToReg_in(MemToReg_in), .MemRead_in(MemRead_in), .MemWrite_in(MemWrite_in),
    .VectorOp_in(VectorOp_in), .alu_in(alu_in), .mux1_in(mux1_in), .RR_in(RR_in),
    .stall(stall), .mem(mif),
    .wb_data(wb_data), .wb_RR(wb_RR), .wb_MemToReg(wb_MemToReg), .wb_valid(wb_valid)
  );

  // RAM environment: registered read, write on the same edge the DUT updates
  logic [31:0] ram [0:65535] = '{default: 32'h0};
  logic        pre_we = 1'b0;
  logic [15:0] pre_addr = '0;
  logic [31:0] pre_data = '0;
  always @(negedge clk) begin
    if (mif.mem_we)  ram[mif.mem_addr] <= mif.mem_wdata;
    else if (pre_we) ram[pre_addr] <= pre_data;
    if (mif.mem_re)  mif.mem_rdata <= ram[mif.mem_addr];
  end

  // Reference memory image
  logic [31:0] mdl [0:65535] = '{default: 32'h0};

  // Expected values for the current instruction
  int                exp_stall;
  logic [DATA_W-1:0] exp_wb_data;
  logic [3:0]        exp_rr;
  logic              exp_m2r;
  logic              exp_wr, exp_rd;
  logic [15:0]       exp_addr[$];
  logic [31:0]       exp_we_data[$];

  // Observations of the current instruction
  int                obs_stall;
  int                obs_wbv_busy;
  logic              obs_wbv_end;
  logic              obs_hold_ok;
  logic              obs_mem_idle;
  logic [DATA_W-1:0] obs_wb_data;
  logic [3:0]        obs_rr;
  logic              obs_m2r;
  logic [15:0]       obs_we_addr[$];
  logic [31:0]       obs_we_data[$];
  logic [15:0]       obs_re_addr[$];

  initial begin
    #500000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1);
  end

  function automatic logic [DATA_W-1:0] rand_vec();
    logic [DATA_W-1:0] v;
    for (int i = 0; i < int'(BEATS); i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  function automatic void model(input logic mr, input logic mw, input logic vec, input logic m2r,
                                input logic [DATA_W-1:0] alu, input logic [DATA_W-1:0] st,
                                input logic [3:0] rr);
    int n;
    logic [15:0] a;
    n = vec ? int'(BEATS) : 1;
    exp_addr.delete();
    exp_we_data.delete();
    exp_rr  = rr;
    exp_m2r = m2r;
    exp_wr  = mw;
    exp_rd  = mr & ~mw;
    exp_wb_data = '0;
    if (!(mr | mw)) begin
      exp_stall   = 0;
      exp_wb_data = alu;
    end else begin
      exp_stall = mw ? n : n + 1;
      for (int i = 0; i < n; i++) begin
        a = alu[15:0] + 16'(i);
        exp_addr.push_back(a);
        if (mw) begin
          exp_we_data.push_back(st[i*32 +: 32]);
          mdl[a] = st[i*32 +: 32];
        end else begin
          exp_wb_data[i*32 +: 32] = mdl[a];
        end
      end
    end
  endfunction

  function automatic bit access_seq_ok();
    bit ok;
    ok = 1'b1;
    if (exp_wr) begin
      if (obs_we_addr.size() != exp_addr.size() || obs_re_addr.size() != 0) return 1'b0;
      foreach (exp_addr[i])
        if (obs_we_addr[i] !== exp_addr[i] || obs_we_data[i] !== exp_we_data[i]) ok = 1'b0;
    end else if (exp_rd) begin
      if (obs_re_addr.size() != exp_addr.size() || obs_we_addr.size() != 0) return 1'b0;
      foreach (exp_addr[i]) if (obs_re_addr[i] !== exp_addr[i]) ok = 1'b0;
    end else begin
      ok = (obs_we_addr.size() == 0) && (obs_re_addr.size() == 0);
    end
    return ok;
  endfunction

  task automatic drive_nop();
    MemRead_in = 1'b0; MemWrite_in = 1'b0; VectorOp_in = 1'b0; MemToReg_in = 1'b0;
  endtask

  // Follows one instruction from acceptance to its retire (first non-stalled cycle)
  task automatic observe();
    logic [DATA_W-1:0] prev_d;
    logic [3:0] prev_rr;
    logic prev_m;
    bit done;
    prev_d = wb_data; prev_rr = wb_RR; prev_m = wb_MemToReg;
    obs_we_addr.delete(); obs_we_data.delete(); obs_re_addr.delete();
    obs_stall = 0; obs_wbv_busy = 0; obs_hold_ok = 1'b1; done = 1'b0;
    for (int k = 0; k < 32 && !done; k++) begin
      @(posedge clk);
      if (!stall) begin
        done = 1'b1;
        obs_wbv_end  = wb_valid;
        obs_wb_data  = wb_data;
        obs_rr       = wb_RR;
        obs_m2r      = wb_MemToReg;
        obs_mem_idle = mif.mem_we | mif.mem_re | (mif.mem_addr != '0);
      end else begin
        obs_stall++;
        if (mif.mem_we) begin
          obs_we_addr.push_back(mif.mem_addr);
          obs_we_data.push_back(mif.mem_wdata);
        end
        if (mif.mem_re) obs_re_addr.push_back(mif.mem_addr);
        if (wb_valid) obs_wbv_busy++;
        if (wb_data !== prev_d || wb_RR !== prev_rr || wb_MemToReg !== prev_m) obs_hold_ok = 1'b0;
      end
    end
    if (!done) obs_stall = 999;
    drive_nop();
  endtask

  task automatic run_op(input logic mr, input logic mw, input logic vec, input logic m2r,
                        input logic [DATA_W-1:0] alu, input logic [DATA_W-1:0] st,
                        input logic [3:0] rr);
    MemRead_in = mr; MemWrite_in = mw; VectorOp_in = vec; MemToReg_in = m2r;
    alu_in = alu; mux1_in = st; RR_in = rr;
    model(mr, mw, vec, m2r, alu, st, rr);
    observe();
  endtask

  task automatic preload(input logic [15:0] a, input logic [31:0] d);
    pre_addr = a; pre_data = d; pre_we = 1'b1;
    @(posedge clk);
    pre_we = 1'b0;
    mdl[a] = d;
  endtask

  task automatic test_reset();
    #1 rst = 1'b0;
    #10;
    checks++;
    if ({stall, mif.mem_we, mif.mem_re, wb_valid, wb_MemToReg} !== 5'b0) begin
      errors++;
      $display("FAIL reset_ctrl got %b want 00000", {stall, mif.mem_we, mif.mem_re, wb_valid, wb_MemToReg});
    end
    checks++;
    if (wb_data !== '0 || wb_RR !== 4'd0 || mif.mem_addr !== 16'd0) begin
      errors++;
      $display("FAIL reset_data got wb_data=%h wb_RR=%0d addr=%h want all zero", wb_data, wb_RR, mif.mem_addr);
    end
    @(posedge clk);
    rst = 1'b1;
  endtask

  task automatic test_passthrough();
    logic [DATA_W-1:0] alu;
    alu = rand_vec();
    alu[31:0] = 32'h0000ABCD;
    run_op(1'b0, 1'b0, 1'b0, 1'b1, alu, '0, 4'd5);
    checks++;
    if (obs_wb_data[31:0] !== 32'h0000ABCD || obs_wb_data !== exp_wb_data) begin
      errors++; $display("FAIL pass_data got %h want %h", obs_wb_data, exp_wb_data);
    end
    checks++;
    if (obs_rr !== 4'd5 || obs_wbv_end !== 1'b1 || obs_m2r !== 1'b1) begin
      errors++; $display("FAIL pass_ctrl got rr=%0d v=%b m2r=%b want 5 1 1", obs_rr, obs_wbv_end, obs_m2r);
    end
    checks++;
    if (obs_stall !== 0 || obs_mem_idle !== 1'b0) begin
      errors++; $display("FAIL pass_nostall got stall=%0d memact=%b want 0 0", obs_stall, obs_mem_idle);
    end
  endtask

  task automatic test_vector_store();
    logic [DATA_W-1:0] st;
    logic [DATA_W-1:0] alu;
    for (int i = 0; i < int'(BEATS); i++) st[i*32 +: 32] = 32'(32'h11111111 * (i + 1));
    alu = '0; alu[15:0] = 16'h0010;
    run_op(1'b0, 1'b1, 1'b1, 1'b0, alu, st, 4'd9);
    checks++;
    if (obs_stall !== 6) begin
      errors++; $display("FAIL vstore_stall got %0d want 6", obs_stall);
    end
    checks++;
    if (!access_seq_ok() || obs_we_addr[0] !== 16'h0010 || obs_we_data[5] !== 32'h66666666) begin
      errors++; $display("FAIL vstore_beats got %0d writes first addr %h want 6 writes from 0010", obs_we_addr.size(), obs_we_addr[0]);
    end
    checks++;
    if (obs_wbv_end !== 1'b1 || obs_wbv_busy !== 0 || obs_wb_data !== '0 || obs_rr !== 4'd9 || !obs_hold_ok) begin
      errors++; $display("FAIL vstore_retire got v=%b busy=%0d data=%h rr=%0d hold=%b", obs_wbv_end, obs_wbv_busy, obs_wb_data, obs_rr, obs_hold_ok);
    end
  endtask

  task automatic test_vector_load();
    logic [DATA_W-1:0] alu;
    logic [DATA_W-1:0] want;
    for (int i = 0; i < int'(BEATS); i++) begin
      preload(16'(16'h0020 + i), 32'(32'hA0 + i));
      want[i*32 +: 32] = 32'(32'hA0 + i);
    end
    alu = rand_vec(); alu[15:0] = 16'h0020;
    run_op(1'b1, 1'b0, 1'b1, 1'b1, alu, '0, 4'd3);
    checks++;
    if (obs_stall !== 7) begin
      errors++; $display("FAIL vload_stall got %0d want 7", obs_stall);
    end
    checks++;
    if (obs_wb_data !== want || obs_rr !== 4'd3 || obs_wbv_end !== 1'b1) begin
      errors++; $display("FAIL vload_data got %h rr=%0d v=%b want %h rr=3 v=1", obs_wb_data, obs_rr, obs_wbv_end, want);
    end
    checks++;
    if (!access_seq_ok()) begin
      errors++; $display("FAIL vload_addrs got %0d reads want 6 from 0020", obs_re_addr.size());
    end
  endtask

  task automatic test_wrap_scalar();
    logic [DATA_W-1:0] alu;
    logic [DATA_W-1:0] want;
    for (int i = 0; i < int'(BEATS); i++) preload(16'(16'hFFFE + i), $urandom);
    preload(16'h0007, 32'hDEADBEEF);
    alu = rand_vec(); alu[15:0] = 16'hFFFE;
    run_op(1'b1, 1'b0, 1'b1, 1'b0, alu, '0, 4'd1);
    checks++;
    if (!access_seq_ok() || obs_re_addr[2] !== 16'h0000 || obs_re_addr[5] !== 16'h0003) begin
      errors++; $display("FAIL wrap_addrs got %0d reads third %h want 6 reads FFFE..0003", obs_re_addr.size(), obs_re_addr[2]);
    end
    checks++;
    if (obs_wb_data !== exp_wb_data) begin
      errors++; $display("FAIL wrap_data got %h want %h", obs_wb_data, exp_wb_data);
    end
    alu = rand_vec(); alu[15:0] = 16'h0007;
    want = '0; want[31:0] = 32'hDEADBEEF;
    run_op(1'b1, 1'b0, 1'b0, 1'b1, alu, rand_vec(), 4'd7);
    checks++;
    if (obs_wb_data !== want || obs_stall !== 2 || obs_wbv_end !== 1'b1) begin
      errors++; $display("FAIL scalar_load got %h stall=%0d v=%b want %h stall=2 v=1", obs_wb_data, obs_stall, obs_wbv_end, want);
    end
  endtask

  task automatic test_hazard();
    logic [DATA_W-1:0] alu;
    alu = '0; alu[15:0] = 16'h0020;
    run_op(1'b1, 1'b0, 1'b1, 1'b1, alu, '0, 4'd2);
    checks++;
    if (obs_wbv_end !== 1'b1 || obs_stall !== 7) begin
      errors++; $display("FAIL hazard_load got v=%b stall=%0d want 1 7", obs_wbv_end, obs_stall);
    end
    alu = '0; alu[7:0] = 8'h42;
    run_op(1'b0, 1'b0, 1'b0, 1'b0, alu, '0, 4'd4);
    checks++;
    if (obs_wb_data !== alu || obs_wbv_end !== 1'b1 || obs_rr !== 4'd4 || obs_stall !== 0) begin
      errors++; $display("FAIL hazard_alu got %h v=%b rr=%0d stall=%0d want 42 1 4 0", obs_wb_data, obs_wbv_end, obs_rr, obs_stall);
    end
  endtask

  task automatic test_back_to_back();
    logic [DATA_W-1:0] alu;
    logic [DATA_W-1:0] st;
    for (int r = 0; r < 2; r++) begin
      st = rand_vec();
      alu = rand_vec(); alu[15:0] = 16'h0060;
      run_op(1'b1, 1'b1, 1'b1, 1'b0, alu, st, 4'd6);
      checks++;
      if (obs_stall !== 6 || !access_seq_ok() || obs_wbv_end !== 1'b1) begin
        errors++; $display("FAIL b2b_store%0d got stall=%0d writes=%0d v=%b want 6 6 1", r, obs_stall, obs_we_addr.size(), obs_wbv_end);
      end
      run_op(1'b1, 1'b0, 1'b1, 1'b0, alu, '0, 4'd8);
      checks++;
      if (obs_wb_data !== st || obs_stall !== 7 || obs_wbv_busy !== 0) begin
        errors++; $display("FAIL b2b_load%0d got %h stall=%0d want %h stall=7", r, obs_wb_data, obs_stall, st);
      end
    end
  endtask

  task automatic test_reset_midop();
    logic [DATA_W-1:0] alu;
    logic [DATA_W-1:0] st;
    alu = '0; alu[15:0] = 16'h0030;
    MemRead_in = 1'b0; MemWrite_in = 1'b1; VectorOp_in = 1'b1; MemToReg_in = 1'b1;
    alu_in = alu; mux1_in = rand_vec(); RR_in = 4'd11;
    repeat (3) @(posedge clk);
    checks++;
    if (mif.mem_we !== 1'b1 || mif.mem_addr !== 16'h0032 || stall !== 1'b1) begin
      errors++; $display("FAIL midop_beat2 got we=%b addr=%h stall=%b want 1 0032 1", mif.mem_we, mif.mem_addr, stall);
    end
    #1 rst = 1'b0;
    drive_nop();
    #1;
    checks++;
    if ({stall, mif.mem_we, mif.mem_re, wb_valid} !== 4'b0 || mif.mem_addr !== 16'd0 ||
        mif.mem_wdata !== 32'd0 || wb_data !== '0 || wb_RR !== 4'd0) begin
      errors++; $display("FAIL midop_reset got stall=%b we=%b addr=%h wb_data=%h want all zero", stall, mif.mem_we, mif.mem_addr, wb_data);
    end
    @(posedge clk);
    rst = 1'b1;
    st = rand_vec();
    alu = '0; alu[15:0] = 16'h0050;
    run_op(1'b0, 1'b1, 1'b1, 1'b0, alu, st, 4'd12);
    checks++;
    if (obs_stall !== 6 || !access_seq_ok() || obs_we_addr[0] !== 16'h0050) begin
      errors++; $display("FAIL midop_fresh got stall=%0d writes=%0d first=%h want 6 6 0050", obs_stall, obs_we_addr.size(), obs_we_addr[0]);
    end
  endtask

  task automatic test_random();
    int kind;
    logic mr, mw, vec;
    logic [DATA_W-1:0] alu;
    for (int t = 0; t < 40; t++) begin
      kind = $urandom_range(0, 3);
      mr  = (kind == 1) || (kind == 3);
      mw  = (kind >= 2);
      vec = $urandom_range(0, 1) == 1;
      alu = rand_vec();
      if ($urandom_range(0, 5) == 0) alu[15:0] = 16'(16'hFFFA + $urandom_range(0, 5));
      else                           alu[15:0] = 16'(16'h1000 + $urandom_range(0, 255));
      run_op(mr, mw, vec, 1'($urandom_range(0, 1)), alu, rand_vec(), 4'($urandom_range(0, 15)));
      checks++;
      if (obs_stall !== exp_stall) begin
        errors++; $display("FAIL rnd%0d_stall got %0d want %0d", t, obs_stall, exp_stall);
      end
      checks++;
      if (obs_wb_data !== exp_wb_data) begin
        errors++; $display("FAIL rnd%0d_data got %h want %h", t, obs_wb_data, exp_wb_data);
      end
      checks++;
      if (obs_wbv_end !== 1'b1 || obs_rr !== exp_rr || obs_m2r !== exp_m2r) begin
        errors++; $display("FAIL rnd%0d_retire got v=%b rr=%0d m2r=%b want 1 %0d %b", t, obs_wbv_end, obs_rr, obs_m2r, exp_rr, exp_m2r);
      end
      checks++;
      if (!access_seq_ok()) begin
        errors++; $display("FAIL rnd%0d_beats got w=%0d r=%0d want %0d beats", t, obs_we_addr.size(), obs_re_addr.size(), exp_addr.size());
      end
      checks++;
      if (obs_wbv_busy !== 0 || !obs_hold_ok) begin
        errors++; $display("FAIL rnd%0d_busy got busy_valid=%0d hold=%b want 0 1", t, obs_wbv_busy, obs_hold_ok);
      end
    end
  endtask

  initial begin
    test_reset();
    test_passthrough();
    test_vector_store();
    test_vector_load();
    test_wrap_scalar();
    test_hazard();
    test_back_to_back();
    test_reset_midop();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
